fir_stream_source: RTL and testbench
====================================

# fir_stream_source

AXI-Stream master that drives test and calibration sample frames into the FIR datapath's slave input (`s_axis_*`). Host logic loads up to DEPTH fixed-point samples through a simple write port. A start pulse then streams them as one or more frames, with `tlast` on each frame's final beat, at one beat per cycle under full backpressure compliance. It is the transmitting end of the FIR input stream.

## Interface
- `AXI_BITWIDTH`, 32: stream data width.
- `BITWIDTH`, 16: stored sample width, signed Q(BITWIDTH-1-FRACT).FRACT.
- `FRACT`, 15: fractional bits. Informational only; no arithmetic depends on it.
- `ADDR_WIDTH`, 6: sample buffer address width; DEPTH = 2**ADDR_WIDTH.
- `clk` in 1: sole clock, rising edge.
- `rstn` in 1: reset. Synchronous and active-high despite the name; asserted = 1.
- `wr_en` in 1: sample buffer write strobe.
- `wr_addr` in ADDR_WIDTH: write address.
- `wr_data` in BITWIDTH: signed sample to store.
- `start` in 1: begin streaming. Sampled only in IDLE.
- `stop` in 1: finish current frame, then end.
- `frame_last` in ADDR_WIDTH: index of the last sample in a frame; frame length = `frame_last`+1.
- `num_frames` in 8: frames to send; 0 = continuous until `stop`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `m_axis_tdata` out AXI_BITWIDTH: sample sign-extended from BITWIDTH to AXI_BITWIDTH.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: last beat of a frame.

## Operation
- Buffer: DEPTH x BITWIDTH, synchronous write, registered (1-cycle) read.
  - `wr_en` is accepted only when `busy`=0; writes while busy are dropped.
  - Contents are not cleared by reset.
- `frame_last` and `num_frames` are latched on the accepted `start`. Later changes have no effect on the run in progress.
- FSM:
  - **IDLE**: `start`=1 -> FETCH; read address 0; sample ptr=0; frame counter=0.
  - **FETCH**: one cycle for the buffer read of address 0 -> STREAM.
  - **STREAM**: `tvalid`=1.
    - Handshake = `tvalid` & `tready`.
    - On handshake with ptr≠frame_last: ptr+1, and issue the read of ptr+1 in the same cycle.
    - On handshake with ptr=frame_last (tlast beat): frame counter+1, ptr wraps to 0, read address 0.
      - Go to DONE if `num_frames`≠0 and the counter reaches `num_frames`, or if the stop flag is set.
      - Otherwise stay in STREAM, so the next frame follows back-to-back.
  - **DONE**: `done`=1 for one cycle, `tvalid`=0 -> IDLE.
- Stop flag:
  - Set by `stop`=1 in FETCH or STREAM; cleared in IDLE.
  - A stop on the tlast handshake cycle itself ends the run at that frame.
  - `stop` in IDLE has no effect.
- `start` while `busy` is ignored.
- `m_axis_tlast` = (ptr == latched frame_last) while `tvalid`=1; otherwise 0.
- `frame_last`=0: every beat is a single-sample frame with `tlast`=1.

## Timing
- Reset (rstn=1 at an edge) forces:
  - state IDLE;
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `done`=0;
  - ptr=0, frame counter=0, stop flag=0.
- Reset mid-frame aborts immediately: `tvalid` drops the next cycle and no `done` pulse is generated.
- `start` accepted at edge N: `busy`=1 from N+1, `tvalid`=1 from N+2 with sample 0.
- While `tvalid`=1 and no handshake, `tdata` and `tlast` are held stable and `tvalid` stays high. `tvalid` never drops without a handshake, except on reset.
- With `tready` held at 1: one beat per cycle, including across frame boundaries, with no bubble.
- Last handshake at edge M: `done`=1 and `tvalid`=0 during cycle M+1; `busy`=0 from M+2.
- A new `start` is accepted from M+2 onward.

## Test plan
- Load samples 0x0001..0x0008 at addresses 0..7; `frame_last`=7, `num_frames`=1; `tready`=1; start -> 8 beats on consecutive cycles with tdata 0x00000001..0x00000008, tlast only on beat 8, `done` pulse one cycle later.
- Load 0x8000 and 0x7FFF; `frame_last`=1, `num_frames`=3 -> 6 beats alternating 0xFFFF8000 / 0x00007FFF, tlast on beats 2, 4 and 6.
- Random `tready` (50%), 16-sample frame, `num_frames`=2 -> data and tlast stable during stalls, exactly 32 handshakes in order, no `tvalid` drop before a handshake.
- `num_frames`=0, `frame_last`=3, `stop` pulsed mid-frame 2 -> frame 2 completes with tlast, then `done`; exactly 8 beats total.
- `wr_en` to address 0 with 0x1234 during a run, plus `start` while busy -> stored sample unchanged on the next run, no restart.
- `rstn`=1 asserted on beat 3 of 8 -> next cycle `tvalid`=0, `busy`=0, no `done`; a fresh start replays from sample 0.

Source files
------------

// File: rtl/fir_stream_source.sv
// fir_stream_source: AXI-Stream master replaying a host-loaded sample buffer as tlast-delimited frames
module fir_stream_source #(
    parameter int AXI_BITWIDTH = 32,
    parameter int BITWIDTH     = 16,
    parameter int FRACT        = 15,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [BITWIDTH-1:0]     wr_data,
    input  logic                    start,
    input  logic                    stop,
    input  logic [ADDR_WIDTH-1:0]   frame_last,
    input  logic [7:0]              num_frames,
    output logic                    busy,
    output logic                    done,
    output logic [AXI_BITWIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);
    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;
    state_t state_q, state_d;
    logic [BITWIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [BITWIDTH-1:0] rd_q;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, last_q;
    logic [7:0] cnt_q, cnt_d, nf_q;
    logic stop_q, stop_d, eof;

    if (FRACT >= BITWIDTH) begin : g_fract_range
        $error("FRACT must leave room for the sign bit");
    end

    assign eof = ptr_q == last_q;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign m_axis_tvalid = state_q == STREAM;
    assign m_axis_tlast = m_axis_tvalid && eof;
    assign m_axis_tdata = {{(AXI_BITWIDTH-BITWIDTH){rd_q[BITWIDTH-1]}}, rd_q};

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        stop_d = state_q == IDLE ? 1'b0 : stop_q | (stop && state_q != DONE);
        case (state_q)
            IDLE: if (start) begin
                state_d = FETCH;
                ptr_d = '0;
                cnt_d = '0;
            end
            FETCH: state_d = STREAM;
            STREAM: if (m_axis_tready) begin
                ptr_d = eof ? '0 : ptr_q + 1'b1;
                cnt_d = eof ? cnt_q + 8'd1 : cnt_q;
                state_d = eof && ((nf_q != '0 && cnt_d == nf_q) || stop_q || stop) ? DONE : STREAM;
            end
            default: state_d = IDLE;
        endcase
    end

    // ptr_d is the address of the beat that will be presented after this edge
    always_ff @(posedge clk) begin
        if (wr_en && !busy) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
            ptr_q <= '0;
            cnt_q <= '0;
            stop_q <= 1'b0;
            rd_q <= '0;
            last_q <= '0;
            nf_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            stop_q <= stop_d;
            rd_q <= mem[ptr_d];
            last_q <= state_q == IDLE && start ? frame_last : last_q;
            nf_q <= state_q == IDLE && start ? num_frames : nf_q;
        end
    end
endmodule

// File: tb/tb_fir_stream_source.sv
// tb_fir_stream_source: directed self-checking bench for the frame streaming source
module tb_fir_stream_source;
    logic clk = 1'b0, rstn = 1'b1, wr_en = 1'b0, start = 1'b0, stop = 1'b0, m_axis_tready = 1'b0;
    logic [5:0] wr_addr = '0, frame_last = '0;
    logic [15:0] wr_data = '0;
    logic [7:0] num_frames = '0;
    logic busy, done, m_axis_tvalid, m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic [15:0] model [64];
    int n_cmp = 0, n_err = 0;

    fir_stream_source dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .frame_last(frame_last), .num_frames(num_frames),
        .busy(busy), .done(done), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] s);
        return {{16{s[15]}}, s};
    endfunction

    task automatic wr(input int a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = 6'(a);
        wr_data = d;
        tick;
        wr_en = 1'b0;
        model[a] = d;
    endtask

    // start a run, then scramble the config inputs to prove they were latched
    task automatic start_run(input int last, input int nf);
        frame_last = 6'(last);
        num_frames = 8'(nf);
        start = 1'b1;
        tick;
        start = 1'b0;
        frame_last = ~6'(last);
        num_frames = 8'd5;
        chk("fetch_busy", {31'd0, busy}, 32'd1);
        chk("fetch_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        tick;
    endtask

    task automatic drain(input int n, input int last, input bit rnd, input int stop_at, input bit poke);
        int idx = 0, cyc = 0, pos;
        while (idx < n && cyc < 400) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stop = idx == stop_at;
            start = poke && cyc == 0;
            wr_en = poke && cyc == 0;
            wr_addr = '0;
            wr_data = 16'h1234;
            pos = idx % (last + 1);
            chk("tvalid", {31'd0, m_axis_tvalid}, 32'd1);
            chk($sformatf("tdata[%0d]", idx), m_axis_tdata, sx(model[pos]));
            chk($sformatf("tlast[%0d]", idx), {31'd0, m_axis_tlast}, {31'd0, pos == last});
            if (m_axis_tready) idx++;
            cyc++;
            tick;
        end
        stop = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        m_axis_tready = 1'b0;
        chk("beats", 32'(idx), 32'(n));
        if (!rnd) chk("cycles", 32'(cyc), 32'(n));
        chk("done", {31'd0, done}, 32'd1);
        chk("done_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        tick;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        chk("rst_tdata", m_axis_tdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rstn = 1'b0;
        for (int i = 0; i < 8; i++) wr(i, 16'(i + 1));
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("idle_stop_busy", {31'd0, busy}, 32'd0);
        start_run(7, 1);
        drain(8, 7, 1'b0, -1, 1'b0);

        wr(0, 16'h8000);
        wr(1, 16'h7FFF);
        start_run(1, 3);
        drain(6, 1, 1'b0, -1, 1'b0);

        for (int i = 0; i < 16; i++) wr(i, 16'(i * 16'h1111 + 16'h0123));
        start_run(15, 2);
        drain(32, 15, 1'b1, -1, 1'b0);

        start_run(3, 0);
        drain(8, 3, 1'b0, 5, 1'b0);
        start_run(3, 0);
        drain(4, 3, 1'b0, 3, 1'b0);

        start_run(1, 1);
        drain(2, 1, 1'b0, -1, 1'b1);
        tick;
        chk("no_restart", {31'd0, busy}, 32'd0);
        start_run(1, 1);
        drain(2, 1, 1'b0, -1, 1'b0);

        start_run(7, 1);
        m_axis_tready = 1'b1;
        tick;
        tick;
        chk("beat3_tdata", m_axis_tdata, sx(model[2]));
        rstn = 1'b1;
        tick;
        rstn = 1'b0;
        m_axis_tready = 1'b0;
        chk("abort_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        tick;
        chk("abort_no_done", {31'd0, done}, 32'd0);
        start_run(7, 1);
        drain(8, 7, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
